// File: rtl/attack_sequencer_pkg.sv
// Shared fighting-game definitions: attack level and phase encodings, default reach and frame
// durations, and the simultaneous-press priority helper.
package attack_sequencer_pkg;

    typedef enum logic [1:0] {
        ATK_NONE = 2'b00,
        ATK_L    = 2'b01,
        ATK_M    = 2'b10,
        ATK_H    = 2'b11
    } atk_level_e;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'b00,
        PH_STARTUP  = 2'b01,
        PH_ACTIVE   = 2'b10,
        PH_RECOVERY = 2'b11
    } phase_e;

    localparam int unsigned POS_W_DEF   = 10;
    localparam int unsigned REACH_L_DEF = 40;
    localparam int unsigned REACH_M_DEF = 56;
    localparam int unsigned REACH_H_DEF = 72;
    localparam int unsigned SU_L_DEF    = 2;
    localparam int unsigned SU_M_DEF    = 4;
    localparam int unsigned SU_H_DEF    = 6;
    localparam int unsigned ACT_L_DEF   = 2;
    localparam int unsigned ACT_M_DEF   = 3;
    localparam int unsigned ACT_H_DEF   = 4;
    localparam int unsigned REC_L_DEF   = 4;
    localparam int unsigned REC_M_DEF   = 8;
    localparam int unsigned REC_H_DEF   = 12;

    // Frame counter width; every phase duration must fit in 1..256 frames.
    localparam int unsigned CNT_W = 8;

    // Presses are ordered {heavy, medium, light}; heavy wins over medium wins over light.
    function automatic atk_level_e press_level(input logic [2:0] press);
        atk_level_e lvl;
        lvl = ATK_NONE;
        if (press[2])      lvl = ATK_H;
        else if (press[1]) lvl = ATK_M;
        else if (press[0]) lvl = ATK_L;
        return lvl;
    endfunction

endpackage

// File: rtl/attack_reach_check.sv
// Reach test for one attack level: opponent must be strictly in front and no further than the
// level's reach. Shared with the hitbox debug overlay.
module attack_reach_check
    import attack_sequencer_pkg::*;
#(
    parameter int unsigned POS_W   = POS_W_DEF,
    parameter int unsigned REACH_L = REACH_L_DEF,
    parameter int unsigned REACH_M = REACH_M_DEF,
    parameter int unsigned REACH_H = REACH_H_DEF
) (
    input  atk_level_e       i_level,
    input  logic [POS_W-1:0] i_pos_self,
    input  logic [POS_W-1:0] i_pos_opp,
    input  logic             i_facing_right,
    output logic             o_in_range_c
);

    logic signed [POS_W:0] w_self;
    logic signed [POS_W:0] w_opp;
    logic signed [POS_W:0] w_dist;
    logic        [POS_W:0] w_reach;

    assign w_self = $signed({1'b0, i_pos_self});
    assign w_opp  = $signed({1'b0, i_pos_opp});
    assign w_dist = i_facing_right ? (w_opp - w_self) : (w_self - w_opp);

    always_comb begin
        w_reach = '0;
        unique case (i_level)
            ATK_L:   w_reach = (POS_W+1)'(REACH_L);
            ATK_M:   w_reach = (POS_W+1)'(REACH_M);
            ATK_H:   w_reach = (POS_W+1)'(REACH_H);
            default: w_reach = '0;
        endcase
    end

    // Negative or zero distance means behind or overlapping: never a hit.
    assign o_in_range_c = !w_dist[POS_W] && (w_dist != '0) && ($unsigned(w_dist) <= w_reach);

endmodule

// File: rtl/attack_sequencer.sv
// Per-fighter attack engine: button edge detect, STARTUP/ACTIVE/RECOVERY sequencing on the
// frame tick, and a single registered hit strobe per connecting attack.
module attack_sequencer
    import attack_sequencer_pkg::*;
#(
    parameter int unsigned POS_W   = POS_W_DEF,
    parameter int unsigned REACH_L = REACH_L_DEF,
    parameter int unsigned REACH_M = REACH_M_DEF,
    parameter int unsigned REACH_H = REACH_H_DEF,
    parameter int unsigned SU_L    = SU_L_DEF,
    parameter int unsigned SU_M    = SU_M_DEF,
    parameter int unsigned SU_H    = SU_H_DEF,
    parameter int unsigned ACT_L   = ACT_L_DEF,
    parameter int unsigned ACT_M   = ACT_M_DEF,
    parameter int unsigned ACT_H   = ACT_H_DEF,
    parameter int unsigned REC_L   = REC_L_DEF,
    parameter int unsigned REC_M   = REC_M_DEF,
    parameter int unsigned REC_H   = REC_H_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_frame_tick,
    input  logic             i_enable,
    input  logic             i_btn_light,
    input  logic             i_btn_medium,
    input  logic             i_btn_heavy,
    input  logic [POS_W-1:0] i_pos_self,
    input  logic [POS_W-1:0] i_pos_opp,
    input  logic             i_facing_right,
    output logic [1:0]       o_attack_state,
    output logic [1:0]       o_phase,
    output logic             o_hit_strobe,
    output logic             o_busy
);

    phase_e           r_phase;
    atk_level_e       r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hit_done;
    logic             r_hit_strobe;
    logic             r_busy;
    logic [2:0]       r_btn_prev;

    logic [2:0]       w_btn;
    logic [2:0]       w_press;
    atk_level_e       w_start_level;
    logic             w_in_range;

    // Frames remaining minus one when entering a phase at a given level.
    function automatic logic [CNT_W-1:0] dur_m1(input phase_e ph, input atk_level_e lv);
        logic [CNT_W-1:0] d;
        d = '0;
        unique case (ph)
            PH_STARTUP:  d = (lv == ATK_H) ? CNT_W'(SU_H - 1)
                           : (lv == ATK_M) ? CNT_W'(SU_M - 1) : CNT_W'(SU_L - 1);
            PH_ACTIVE:   d = (lv == ATK_H) ? CNT_W'(ACT_H - 1)
                           : (lv == ATK_M) ? CNT_W'(ACT_M - 1) : CNT_W'(ACT_L - 1);
            PH_RECOVERY: d = (lv == ATK_H) ? CNT_W'(REC_H - 1)
                           : (lv == ATK_M) ? CNT_W'(REC_M - 1) : CNT_W'(REC_L - 1);
            default:     d = '0;
        endcase
        return d;
    endfunction

    assign w_btn         = {i_btn_heavy, i_btn_medium, i_btn_light};
    assign w_press       = w_btn & ~r_btn_prev;
    assign w_start_level = press_level(w_press);

    attack_reach_check #(
        .POS_W   (POS_W),
        .REACH_L (REACH_L),
        .REACH_M (REACH_M),
        .REACH_H (REACH_H)
    ) u_reach (
        .i_level        (r_level),
        .i_pos_self     (i_pos_self),
        .i_pos_opp      (i_pos_opp),
        .i_facing_right (i_facing_right),
        .o_in_range_c   (w_in_range)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= PH_IDLE;
            r_level      <= ATK_NONE;
            r_cnt        <= '0;
            r_hit_done   <= 1'b0;
            r_hit_strobe <= 1'b0;
            r_busy       <= 1'b0;
            r_btn_prev   <= '0;
        end else begin
            r_btn_prev   <= w_btn;
            r_hit_strobe <= 1'b0;
            if (!i_enable) begin
                // Round left the fight state: abort without issuing a hit.
                r_phase <= PH_IDLE;
                r_level <= ATK_NONE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_phase)
                    PH_IDLE: begin
                        if (|w_press) begin
                            r_phase    <= PH_STARTUP;
                            r_level    <= w_start_level;
                            r_cnt      <= dur_m1(PH_STARTUP, w_start_level);
                            r_hit_done <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                    PH_STARTUP: begin
                        if (i_frame_tick) begin
                            if (r_cnt == '0) begin
                                r_phase <= PH_ACTIVE;
                                r_cnt   <= dur_m1(PH_ACTIVE, r_level);
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    PH_ACTIVE: begin
                        if (!r_hit_done && w_in_range) begin
                            r_hit_strobe <= 1'b1;
                            r_hit_done   <= 1'b1;
                        end
                        if (i_frame_tick) begin
                            if (r_cnt == '0) begin
                                r_phase <= PH_RECOVERY;
                                r_cnt   <= dur_m1(PH_RECOVERY, r_level);
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    PH_RECOVERY: begin
                        if (i_frame_tick) begin
                            if (r_cnt == '0) begin
                                r_phase <= PH_IDLE;
                                r_level <= ATK_NONE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_phase <= PH_IDLE;
                        r_level <= ATK_NONE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_attack_state = r_level;
    assign o_phase        = r_phase;
    assign o_hit_strobe   = r_hit_strobe;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_attack_sequencer.sv
// Directed bench for attack_sequencer: phase timing per level, single-hit behaviour, reach
// boundaries, button edge handling, enable abort and reset.
module tb_attack_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_frame_tick = 1'b0;
    logic       i_enable = 1'b1;
    logic       i_btn_light = 1'b0;
    logic       i_btn_medium = 1'b0;
    logic       i_btn_heavy = 1'b0;
    logic [9:0] i_pos_self = 10'd100;
    logic [9:0] i_pos_opp = 10'd130;
    logic       i_facing_right = 1'b1;
    logic [1:0] o_attack_state;
    logic [1:0] o_phase;
    logic       o_hit_strobe;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_strobe = 0;

    attack_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .i_frame_tick   (i_frame_tick),
        .i_enable       (i_enable),
        .i_btn_light    (i_btn_light),
        .i_btn_medium   (i_btn_medium),
        .i_btn_heavy    (i_btn_heavy),
        .i_pos_self     (i_pos_self),
        .i_pos_opp      (i_pos_opp),
        .i_facing_right (i_facing_right),
        .o_attack_state (o_attack_state),
        .o_phase        (o_phase),
        .o_hit_strobe   (o_hit_strobe),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    // One clock; outputs sampled 1 time unit after the edge, strobe cycles tallied.
    task automatic step();
        @(posedge clk);
        #1;
        if (o_hit_strobe === 1'b1) n_strobe++;
    endtask

    // One video frame: a single tick clock followed by two quiet clocks.
    task automatic frame();
        i_frame_tick = 1'b1;
        step();
        i_frame_tick = 1'b0;
        step();
        step();
    endtask

    // Phase expected after k ticks of an attack with the given durations.
    function automatic logic [1:0] exp_phase(input int k, input int su, input int act, input int rec);
        if (k < su)                 return 2'b01;
        else if (k < su + act)      return 2'b10;
        else if (k < su + act + rec) return 2'b11;
        return 2'b00;
    endfunction

    task automatic abort_attack();
        i_enable = 1'b0;
        step();
        i_enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_vec++;
        if (o_phase !== 2'b00 || o_attack_state !== 2'b00 || o_hit_strobe !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: phase=%b state=%b strobe=%b busy=%b need 00/00/0/0",
                     o_phase, o_attack_state, o_hit_strobe, o_busy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_light_hit();
        logic [1:0] ep;
        i_pos_opp = 10'd130;
        i_facing_right = 1'b1;
        n_strobe = 0;
        i_btn_light = 1'b1;
        step();
        i_btn_light = 1'b0;
        n_vec++;
        if (o_phase !== 2'b01 || o_attack_state !== 2'b01 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL light_start: phase=%b state=%b busy=%b need 01/01/1", o_phase, o_attack_state, o_busy);
        end
        for (int k = 1; k <= 8; k++) begin
            frame();
            ep = exp_phase(k, 2, 2, 4);
            n_vec++;
            if (o_phase !== ep || o_attack_state !== ((ep == 2'b00) ? 2'b00 : 2'b01) || o_busy !== (ep != 2'b00)) begin
                n_err++;
                $display("FAIL light_tick%0d: phase=%b state=%b busy=%b need phase=%b", k, o_phase, o_attack_state, o_busy, ep);
            end
        end
        n_vec++;
        if (n_strobe !== 1) begin
            n_err++;
            $display("FAIL light_strobes: got %0d need 1", n_strobe);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] ep;
        i_pos_opp = 10'd130;
        n_strobe = 0;
        i_btn_heavy = 1'b1;
        i_btn_light = 1'b1;
        step();
        i_btn_heavy = 1'b0;
        i_btn_light = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) frame();
            ep = exp_phase(k, 6, 4, 12);
            n_vec++;
            if (o_phase !== ep || o_attack_state !== ((ep == 2'b00) ? 2'b00 : 2'b11)) begin
                n_err++;
                $display("FAIL simul_tick%0d: phase=%b state=%b need phase=%b", k, o_phase, o_attack_state, ep);
            end
        end
        n_vec++;
        if (n_strobe !== 1) begin
            n_err++;
            $display("FAIL simul_strobes: got %0d need 1", n_strobe);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] ep;
        for (int pass = 0; pass < 2; pass++) begin
            // pass 0: 60 px in front (beyond 56); pass 1: 30 px behind
            i_pos_opp = (pass == 0) ? 10'd160 : 10'd130;
            i_facing_right = (pass == 0);
            n_strobe = 0;
            i_btn_medium = 1'b1;
            step();
            i_btn_medium = 1'b0;
            for (int k = 1; k <= 15; k++) begin
                frame();
                ep = exp_phase(k, 4, 3, 8);
                n_vec++;
                if (o_phase !== ep || o_attack_state !== ((ep == 2'b00) ? 2'b00 : 2'b10)) begin
                    n_err++;
                    $display("FAIL oor%0d_tick%0d: phase=%b state=%b need phase=%b", pass, k, o_phase, o_attack_state, ep);
                end
            end
            n_vec++;
            if (n_strobe !== 0) begin
                n_err++;
                $display("FAIL oor%0d_strobes: got %0d need 0", pass, n_strobe);
            end
        end
        i_facing_right = 1'b1;
        i_pos_opp = 10'd130;
    endtask

    task automatic test_hold_repress();
        logic [1:0] ep;
        n_strobe = 0;
        i_btn_heavy = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            frame();
            ep = exp_phase(k, 6, 4, 12);
            n_vec++;
            if (o_phase !== ep) begin
                n_err++;
                $display("FAIL hold_tick%0d: phase=%b need %b", k, o_phase, ep);
            end
        end
        i_btn_heavy = 1'b0;
        step();
        n_vec++;
        if (n_strobe !== 1) begin
            n_err++;
            $display("FAIL hold_strobes: got %0d need 1", n_strobe);
        end
        i_btn_light = 1'b1;
        step();
        i_btn_light = 1'b0;
        for (int k = 1; k <= 4; k++) frame();
        i_btn_medium = 1'b1;
        step();
        i_btn_medium = 1'b0;
        n_vec++;
        if (o_phase !== 2'b11 || o_attack_state !== 2'b01) begin
            n_err++;
            $display("FAIL repress_recovery: phase=%b state=%b need 11/01", o_phase, o_attack_state);
        end
        for (int k = 5; k <= 8; k++) frame();
        n_vec++;
        if (o_phase !== 2'b00 || o_attack_state !== 2'b00) begin
            n_err++;
            $display("FAIL repress_end: phase=%b state=%b need 00/00", o_phase, o_attack_state);
        end
        i_btn_medium = 1'b1;
        step();
        i_btn_medium = 1'b0;
        n_vec++;
        if (o_phase !== 2'b01 || o_attack_state !== 2'b10) begin
            n_err++;
            $display("FAIL repress_idle: phase=%b state=%b need 01/10", o_phase, o_attack_state);
        end
        abort_attack();
    endtask

    task automatic test_enable_drop();
        i_pos_opp = 10'd200;
        n_strobe = 0;
        i_btn_light = 1'b1;
        step();
        i_btn_light = 1'b0;
        frame();
        frame();
        n_vec++;
        if (o_phase !== 2'b10) begin
            n_err++;
            $display("FAIL endrop_active: phase=%b need 10", o_phase);
        end
        i_enable = 1'b0;
        i_pos_opp = 10'd130;
        step();
        n_vec++;
        if (o_phase !== 2'b00 || o_attack_state !== 2'b00 || o_busy !== 1'b0 || o_hit_strobe !== 1'b0) begin
            n_err++;
            $display("FAIL endrop_idle: phase=%b state=%b busy=%b strobe=%b need 00/00/0/0",
                     o_phase, o_attack_state, o_busy, o_hit_strobe);
        end
        i_btn_light = 1'b1;
        step();
        i_btn_light = 1'b0;
        step();
        n_vec++;
        if (o_phase !== 2'b00 || n_strobe !== 0) begin
            n_err++;
            $display("FAIL endrop_press: phase=%b strobes=%0d need 00/0", o_phase, n_strobe);
        end
        i_enable = 1'b1;
        step();
    endtask

    task automatic test_reset_recovery();
        i_pos_opp = 10'd130;
        i_btn_light = 1'b1;
        step();
        i_btn_light = 1'b0;
        for (int k = 1; k <= 5; k++) frame();
        n_vec++;
        if (o_phase !== 2'b11) begin
            n_err++;
            $display("FAIL rstrec_pre: phase=%b need 11", o_phase);
        end
        reset = 1'b1;
        step();
        n_vec++;
        if (o_phase !== 2'b00 || o_attack_state !== 2'b00 || o_hit_strobe !== 1'b0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstrec_post: phase=%b state=%b strobe=%b busy=%b need 00/00/0/0",
                     o_phase, o_attack_state, o_hit_strobe, o_busy);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_late_range();
        i_pos_opp = 10'd180;
        n_strobe = 0;
        i_btn_heavy = 1'b1;
        step();
        i_btn_heavy = 1'b0;
        for (int k = 1; k <= 7; k++) frame();
        n_vec++;
        if (o_phase !== 2'b10 || n_strobe !== 0) begin
            n_err++;
            $display("FAIL late_before: phase=%b strobes=%0d need 10/0", o_phase, n_strobe);
        end
        i_pos_opp = 10'd150;
        step();
        n_vec++;
        if (o_hit_strobe !== 1'b1) begin
            n_err++;
            $display("FAIL late_strobe: strobe=%b need 1", o_hit_strobe);
        end
        for (int k = 8; k <= 22; k++) frame();
        n_vec++;
        if (n_strobe !== 1 || o_phase !== 2'b00) begin
            n_err++;
            $display("FAIL late_total: strobes=%0d phase=%b need 1/00", n_strobe, o_phase);
        end
        i_pos_opp = 10'd130;
    endtask

    task automatic test_tick_on_start();
        i_btn_light = 1'b1;
        i_frame_tick = 1'b1;
        step();
        i_btn_light = 1'b0;
        i_frame_tick = 1'b0;
        step();
        frame();
        n_vec++;
        if (o_phase !== 2'b01) begin
            n_err++;
            $display("FAIL tickstart_1: phase=%b need 01", o_phase);
        end
        frame();
        n_vec++;
        if (o_phase !== 2'b10) begin
            n_err++;
            $display("FAIL tickstart_2: phase=%b need 10", o_phase);
        end
        abort_attack();
    endtask

    initial begin
        test_reset();
        test_light_hit();
        test_simultaneous();
        test_out_of_range();
        test_hold_repress();
        test_enable_drop();
        test_reset_recovery();
        test_late_range();
        test_tick_on_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
